icache_stream_prefetcher: RTL and testbench
===========================================

Name: icache_stream_prefetcher

Overview:
Next-line instruction prefetcher with a small FIFO stream buffer, placed between the icache miss port and the memory arbiter's icache and prefetch ports. Demand misses that match the buffer head are served locally. All other misses are forwarded to the arbiter. After each forwarded miss the block refills the buffer with the next sequential 32-byte lines through the arbiter's prefetch port.

Parameters:
DEPTH, 2, stream buffer entries (power of two, >=1)
PF_ENABLE, 1, 0 = pure pass-through: no prefetch, buffer never valid

Ports:
clk  in  1  clock
rst  in  1  reset
pf_icache_read  in  1  icache line read request, held until resp
pf_icache_address  in  32  icache request address
pf_icache_resp  out  1  one-cycle completion to icache
pf_icache_rdata  out  256  line data, valid with resp, else 0
arb_icache_read  out  1  demand read to arbiter
arb_icache_address  out  32  demand address (unmodified request address)
arb_icache_resp  in  1  arbiter demand completion
arb_icache_rdata  in  256  arbiter demand data
arb_pf_read  out  1  prefetch read to arbiter
arb_pf_address  out  32  prefetch address, line aligned ({line,5'b0})
arb_pf_resp  in  1  arbiter prefetch completion
arb_pf_rdata  in  256  arbiter prefetch data

Behaviour:
- Interface: one clock, clk; rst is synchronous, active-high. Reset clears the FSMs, all valid bits, the entry count and stream_active. All outputs are 0 in the cycle after rst is sampled high; an in-flight arb_pf_read is dropped (the arbiter shares rst).
- Line tag = address[31:5]. Only the head (oldest) entry is ever compared.
- Demand FSM states: D_IDLE, D_HIT, D_MISS.
- D_IDLE:
  - A lookup happens only when pf_icache_read=1 and the prefetch FSM is not in P_WAIT. During P_WAIT the demand waits, and lookup happens the cycle after arb_pf_resp, so a freshly written entry is visible.
  - Head valid and tag match -> D_HIT.
  - Otherwise -> D_MISS.
- D_HIT (1 cycle): pf_icache_resp=1, pf_icache_rdata=head data, pop head; -> D_IDLE. Hit latency: resp 1 cycle after the lookup cycle.
- D_MISS:
  - Entry cycle: flush the buffer (all invalid, count=0) and clear stream_active.
  - arb_icache_read=1 with arb_icache_address=pf_icache_address. resp and rdata are passed through combinationally (same cycle).
  - On arb_icache_resp: next_pf_line = tag+1; stream_active=PF_ENABLE, except 0 when tag = 27'h7FFFFFF (no wrap past the top of memory); -> D_IDLE.
- Prefetch FSM states: P_IDLE, P_WAIT.
  - P_IDLE -> P_WAIT when stream_active, count<DEPTH, demand FSM in D_IDLE, and pf_icache_read=0.
  - P_WAIT: arb_pf_read=1 with arb_pf_address={next_pf_line,5'b0}, held until arb_pf_resp. Never deasserted early except on reset.
  - On arb_pf_resp: push {tag,data} at tail; next_pf_line++; if the old line was 27'h7FFFFFF, clear stream_active; -> P_IDLE.
- Full buffer: no issue. After a pop, the next issue is allowed once its conditions hold.
- Push and pop never coincide: a pop happens only in D_HIT, and D_HIT is never entered while in P_WAIT.
- Requester contract: the icache deasserts read the cycle after resp. A read still high in D_IDLE is treated as a new request.
- arb_icache_read and arb_pf_read are never both high.

Decomposition:
- Package icache_pf_pkg: LINE_W=256, OFFSET_W=5, TAG_W=27, enums for demand_state_t and pf_state_t, typedef pf_entry_t {valid, tag, data}.
- Sub-module pf_stream_buffer: DEPTH-entry FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head_valid, head_tag, head_data, count, full.
  - flush has priority over push.

Test Plan:
- Cold miss: request 0x0000_0104 -> arb_icache_read, address 0x104. Arbiter resp with data A -> pf_icache_resp=1, rdata=A, same cycle. Then arb_pf_read at 0x120, then at 0x140, then stops (full, DEPTH=2).
- Sequential hit: after the cold miss, request 0x0000_0128 -> resp 1 cycle after lookup with 0x120 data and no arb_icache_read. Then a prefetch at 0x160 is issued.
- Non-head miss: buffer holds {0x120,0x140}, request 0x400 -> flush, arb_icache_read at 0x400, then prefetches at 0x420 and 0x440.
- Demand during in-flight prefetch: request 0x120 while prefetch 0x120 is pending -> no arb_icache_read. Hit resp 2 cycles after arb_pf_resp.
- Top of memory: miss at 0xFFFF_FFE0 -> resp passes through; arb_pf_read stays 0.
- Reset mid-prefetch: rst in P_WAIT -> arb_pf_read=0 the next cycle, buffer empty. A following request to 0x120 is forwarded as a miss.

Source files
------------

// File: rtl/icache_stream_prefetcher_pkg.sv
// Shared widths, FSM encodings and stream-buffer entry layout for the
// icache next-line prefetcher.
package icache_pf_pkg;

   localparam int unsigned LINE_W   = 256;
   localparam int unsigned OFFSET_W = 5;
   localparam int unsigned TAG_W    = 27;
   localparam int unsigned ADDR_W   = 32;

   localparam logic [1:0] D_IDLE_ENC = 2'b00;
   localparam logic [1:0] D_HIT_ENC  = 2'b01;
   localparam logic [1:0] D_MISS_ENC = 2'b10;
   localparam logic [0:0] P_IDLE_ENC = 1'b0;
   localparam logic [0:0] P_WAIT_ENC = 1'b1;

   typedef enum logic [1:0] {
      D_IDLE = D_IDLE_ENC,
      D_HIT  = D_HIT_ENC,
      D_MISS = D_MISS_ENC
   } demand_state_t;

   typedef enum logic [0:0] {
      P_IDLE = P_IDLE_ENC,
      P_WAIT = P_WAIT_ENC
   } pf_state_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] data;
   } pf_entry_t;

   function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_W];
   endfunction

endpackage

// File: rtl/icache_stream_prefetcher_if.sv
// Line-read request/response bus; master issues read/address, slave returns
// a one-cycle resp with the line data.
interface icache_stream_prefetcher_if;
   import icache_pf_pkg::*;

   logic              read;
   logic [ADDR_W-1:0] address;
   logic              resp;
   logic [LINE_W-1:0] rdata;

   modport master (output read, output address, input resp, input rdata);
   modport slave  (input read, input address, output resp, output rdata);

endinterface

// File: rtl/icache_stream_prefetcher_buf.sv
// DEPTH-entry FIFO of prefetched lines; only the head is exposed for lookup.
module pf_stream_buffer
   import icache_pf_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [TAG_W-1:0]               push_tag,
   input  logic [LINE_W-1:0]              push_data,
   output logic                           head_valid,
   output logic [TAG_W-1:0]               head_tag,
   output logic [LINE_W-1:0]              head_data,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   pf_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      head_valid = entries[head].valid;
      head_tag   = entries[head].tag;
      head_data  = entries[head].data;
      full       = (count == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
         end
      end else begin
         if (push) begin
            entries[tail] <= '{valid: 1'b1, tag: push_tag, data: push_data};
            tail          <= next_ptr(tail);
         end
         if (pop) begin
            entries[head].valid <= 1'b0;
            head                <= next_ptr(head);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/icache_stream_prefetcher.sv
// Next-line icache prefetcher: serves demand hits from the stream-buffer head,
// forwards misses to the arbiter and refills the buffer with following lines.
module icache_stream_prefetcher
   import icache_pf_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned PF_ENABLE = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   icache_stream_prefetcher_if.slave   pf_icache,
   icache_stream_prefetcher_if.master  arb_icache,
   icache_stream_prefetcher_if.master  arb_pf
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   demand_state_t     d_state;
   pf_state_t         p_state;
   logic              stream_active;
   logic [TAG_W-1:0]  next_pf_line;

   logic              head_valid;
   logic [TAG_W-1:0]  head_tag;
   logic [LINE_W-1:0] head_data;
   logic [CNT_W-1:0]  buf_count;
   logic              buf_full_unused;

   logic [TAG_W-1:0]  req_tag;
   logic              lookup;
   logic              hit;
   logic              flush;
   logic              push;
   logic              pop;
   logic              issue;

   always_comb begin
      req_tag = line_tag(pf_icache.address);
      // A pending prefetch may be filling the line being asked for, so the
      // lookup is held off until its data has landed in the buffer.
      lookup  = pf_icache.read && (d_state == D_IDLE) && (p_state != P_WAIT);
      hit     = head_valid && (head_tag == req_tag);
      flush   = lookup && !hit;
      pop     = (d_state == D_HIT);
      push    = (p_state == P_WAIT) && arb_pf.resp;
      issue   = (p_state == P_IDLE) && stream_active && (buf_count < CNT_W'(DEPTH))
                && (d_state == D_IDLE) && !pf_icache.read;
   end

   always_comb begin
      pf_icache.resp     = 1'b0;
      pf_icache.rdata    = '0;
      arb_icache.read    = 1'b0;
      arb_icache.address = '0;
      arb_pf.read        = 1'b0;
      arb_pf.address     = '0;
      case (d_state)
         D_HIT: begin
            pf_icache.resp  = 1'b1;
            pf_icache.rdata = head_data;
         end
         D_MISS: begin
            arb_icache.read    = 1'b1;
            arb_icache.address = pf_icache.address;
            pf_icache.resp     = arb_icache.resp;
            pf_icache.rdata    = arb_icache.resp ? arb_icache.rdata : '0;
         end
         default: ;
      endcase
      if (p_state == P_WAIT) begin
         arb_pf.read    = 1'b1;
         arb_pf.address = {next_pf_line, {OFFSET_W{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_state       <= D_IDLE;
         p_state       <= P_IDLE;
         stream_active <= 1'b0;
         next_pf_line  <= '0;
      end else begin
         case (d_state)
            D_IDLE: begin
               if (lookup) begin
                  d_state <= hit ? D_HIT : D_MISS;
                  if (!hit) begin
                     stream_active <= 1'b0;
                  end
               end
            end
            D_HIT: d_state <= D_IDLE;
            D_MISS: begin
               if (arb_icache.resp) begin
                  d_state       <= D_IDLE;
                  next_pf_line  <= req_tag + 1'b1;
                  stream_active <= (PF_ENABLE != 0) && (req_tag != '1);
               end
            end
            default: d_state <= D_IDLE;
         endcase

         case (p_state)
            P_IDLE: begin
               if (issue) begin
                  p_state <= P_WAIT;
               end
            end
            P_WAIT: begin
               if (arb_pf.resp) begin
                  p_state      <= P_IDLE;
                  next_pf_line <= next_pf_line + 1'b1;
                  if (next_pf_line == '1) begin
                     stream_active <= 1'b0;
                  end
               end
            end
            default: p_state <= P_IDLE;
         endcase
      end
   end

   pf_stream_buffer #(.DEPTH(DEPTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_tag   (next_pf_line),
      .push_data  (arb_pf.rdata),
      .head_valid (head_valid),
      .head_tag   (head_tag),
      .head_data  (head_data),
      .count      (buf_count),
      .full       (buf_full_unused)
   );

endmodule

// File: tb/tb_icache_stream_prefetcher.sv
// Directed bench for icache_stream_prefetcher with DEPTH=2, PF_ENABLE=1.
module tb_icache_stream_prefetcher;
   import icache_pf_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   icache_stream_prefetcher_if pf_icache_bus ();
   icache_stream_prefetcher_if arb_icache_bus ();
   icache_stream_prefetcher_if arb_pf_bus ();

   icache_stream_prefetcher #(.DEPTH(2), .PF_ENABLE(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .pf_icache  (pf_icache_bus.slave),
      .arb_icache (arb_icache_bus.master),
      .arb_pf     (arb_pf_bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] line_data(input logic [31:0] seed);
      return {8{seed}};
   endfunction

   task automatic demand_miss(input string tag, input logic [31:0] addr, input logic [255:0] data);
      pf_icache_bus.read    = 1'b1;
      pf_icache_bus.address = addr;
      step();
      check({tag, "_arb_read"}, arb_icache_bus.read, 1);
      check({tag, "_arb_addr"}, arb_icache_bus.address, addr);
      check({tag, "_no_early_resp"}, pf_icache_bus.resp, 0);
      arb_icache_bus.resp  = 1'b1;
      arb_icache_bus.rdata = data;
      #1;
      check({tag, "_resp"}, pf_icache_bus.resp, 1);
      check({tag, "_rdata"}, pf_icache_bus.rdata, data);
      step();
      arb_icache_bus.resp   = 1'b0;
      arb_icache_bus.rdata  = '0;
      pf_icache_bus.read    = 1'b0;
      pf_icache_bus.address = '0;
   endtask

   task automatic wait_pf(input string tag, input logic [31:0] addr);
      int unsigned n = 0;
      while (!arb_pf_bus.read && n < 20) begin
         step();
         n++;
      end
      check({tag, "_req"}, arb_pf_bus.read, 1);
      check({tag, "_addr"}, arb_pf_bus.address, addr);
      check({tag, "_excl"}, arb_icache_bus.read, 0);
   endtask

   task automatic serve_pf(input string tag, input logic [31:0] addr, input logic [255:0] data);
      wait_pf(tag, addr);
      arb_pf_bus.resp  = 1'b1;
      arb_pf_bus.rdata = data;
      step();
      arb_pf_bus.resp  = 1'b0;
      arb_pf_bus.rdata = '0;
   endtask

   task automatic expect_no_pf(input string tag, input int unsigned cycles);
      logic seen = 1'b0;
      for (int unsigned i = 0; i < cycles; i++) begin
         step();
         seen |= arb_pf_bus.read;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      logic seen;
      pf_icache_bus.read    = 1'b0;
      pf_icache_bus.address = '0;
      arb_icache_bus.resp   = 1'b0;
      arb_icache_bus.rdata  = '0;
      arb_pf_bus.resp       = 1'b0;
      arb_pf_bus.rdata      = '0;

      step();
      check("rst_resp", pf_icache_bus.resp, 0);
      check("rst_rdata", pf_icache_bus.rdata, 0);
      check("rst_arb_read", arb_icache_bus.read, 0);
      check("rst_pf_read", arb_pf_bus.read, 0);
      check("rst_pf_addr", arb_pf_bus.address, 0);
      step();
      rst = 1'b0;
      step();

      // Cold miss followed by two prefetches that fill the buffer.
      demand_miss("cold", 32'h0000_0104, line_data(32'hAAAA_0104));
      serve_pf("pf120", 32'h0000_0120, line_data(32'hBBBB_0120));
      serve_pf("pf140", 32'h0000_0140, line_data(32'hBBBB_0140));
      expect_no_pf("full_no_issue", 5);

      // Sequential hit on the head entry.
      pf_icache_bus.read    = 1'b1;
      pf_icache_bus.address = 32'h0000_0128;
      #1;
      check("hit_no_early_resp", pf_icache_bus.resp, 0);
      step();
      check("hit_resp", pf_icache_bus.resp, 1);
      check("hit_rdata", pf_icache_bus.rdata, line_data(32'hBBBB_0120));
      check("hit_no_arb", arb_icache_bus.read, 0);
      step();
      pf_icache_bus.read    = 1'b0;
      pf_icache_bus.address = '0;
      check("hit_one_cycle", pf_icache_bus.resp, 0);
      serve_pf("pf160", 32'h0000_0160, line_data(32'hBBBB_0160));

      // Miss on a line not at the head flushes the buffer.
      pf_icache_bus.read    = 1'b1;
      pf_icache_bus.address = 32'h0000_0400;
      step();
      check("nh_flush_count", dut.u_buf.count, 0);
      check("nh_arb_read", arb_icache_bus.read, 1);
      check("nh_arb_addr", arb_icache_bus.address, 32'h0000_0400);
      arb_icache_bus.resp  = 1'b1;
      arb_icache_bus.rdata = line_data(32'hCCCC_0400);
      #1;
      check("nh_rdata", pf_icache_bus.rdata, line_data(32'hCCCC_0400));
      step();
      arb_icache_bus.resp   = 1'b0;
      arb_icache_bus.rdata  = '0;
      pf_icache_bus.read    = 1'b0;
      serve_pf("pf420", 32'h0000_0420, line_data(32'hDDDD_0420));
      serve_pf("pf440", 32'h0000_0440, line_data(32'hDDDD_0440));

      // Demand arrives while the matching prefetch is still outstanding.
      demand_miss("m100", 32'h0000_0100, line_data(32'hAAAA_0100));
      wait_pf("inflight", 32'h0000_0120);
      pf_icache_bus.read    = 1'b1;
      pf_icache_bus.address = 32'h0000_0120;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         seen |= arb_icache_bus.read | pf_icache_bus.resp;
      end
      check("inflight_demand_waits", seen, 0);
      arb_pf_bus.resp  = 1'b1;
      arb_pf_bus.rdata = line_data(32'hEEEE_0120);
      step();
      arb_pf_bus.resp  = 1'b0;
      arb_pf_bus.rdata = '0;
      check("inflight_resp_not_yet", pf_icache_bus.resp, 0);
      step();
      check("inflight_resp", pf_icache_bus.resp, 1);
      check("inflight_rdata", pf_icache_bus.rdata, line_data(32'hEEEE_0120));
      check("inflight_no_arb", arb_icache_bus.read, 0);
      step();
      pf_icache_bus.read    = 1'b0;
      pf_icache_bus.address = '0;
      serve_pf("pf140b", 32'h0000_0140, line_data(32'hEEEE_0140));
      serve_pf("pf160b", 32'h0000_0160, line_data(32'hEEEE_0160));

      // Top of memory: no prefetch may wrap to line 0.
      demand_miss("top", 32'hFFFF_FFE0, line_data(32'hFFFF_FFE0));
      expect_no_pf("top_no_pf", 8);

      // Reset while a prefetch is outstanding.
      demand_miss("m200", 32'h0000_0200, line_data(32'hAAAA_0200));
      wait_pf("pf220", 32'h0000_0220);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstpf_pf_read", arb_pf_bus.read, 0);
      check("rstpf_count", dut.u_buf.count, 0);
      check("rstpf_arb_read", arb_icache_bus.read, 0);
      demand_miss("after_rst", 32'h0000_0120, line_data(32'h1234_0120));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
